alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I execute ALU.
- Registered integer datapath of width WIDTH with a valid/ready handshake on input and output.
- Base ops (add/sub/logic/shift/compare) complete in one cycle.
- RV32M-style multiply/divide ops run iteratively over WIDTH cycles; the EX stage stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- op  in  5  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {o,c,n,z}, registered.
- err  out  1  illegal/unsupported op flagged with result.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 SLTU.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18-31 illegal.
- Adder: sum = a + (sub ? ~b : b) + sub. This sum is used for ADD/SUB/SLT/SLTU.
- Compares:
  - SLT = sum[MSB] ^ o.
  - SLTU = ~cout of the subtraction.
  - Both results are zero-extended.
- Shifts use b[SHW-1:0]. SRA is arithmetic.
- Flags:
  - z = (result==0); n = result[MSB].
  - c = cout and o = signed overflow, only for ADD/SUB/SLT/SLTU; otherwise 0.
- States: IDLE, CALC, DONE.
- in_ready = 1 only in IDLE. Accept = in_valid & in_ready; a, b and op are latched on accept.
- IDLE -> DONE on accept of a base op, illegal op, DIV/REM by zero, or signed overflow (MIN / -1). Latency 1: out_valid is high the cycle after accept.
- IDLE -> CALC on accept of any other mul/div op. The counter loads WIDTH-1.
- CALC: one shift-add (mul) or restoring-subtract (div) step per cycle. After WIDTH steps go to DONE, so out_valid rises exactly WIDTH+1 cycles after accept.
- DONE: out_valid = 1; result, flags and err are held stable. When out_ready = 1, go to IDLE and drop out_valid the next cycle. No bypass: minimum of 2 cycles per op.
- Signed mul/div: operate on magnitudes, then negate per RISC-V sign rules. The remainder takes the dividend's sign.
  - MUL returns the low WIDTH bits of the product; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide by zero: quotient all ones; remainder = a.
- Signed overflow (DIV of MIN by -1): quotient MIN; remainder 0.
- Illegal op: result 0, flags 0, err 1. err is 0 for all legal ops.
- in_valid while not IDLE: ignored, request not consumed.
- Reset (asynchronous, any state, including mid-CALC):
  - state IDLE; in_ready 1; out_valid 0; result 0; flags 0; err 0; counter 0.
  - Any in-flight op is discarded.

Optional Feature:
- ALU_MULDIV_EN defined: ops 10-17 are implemented as above.
- ALU_MULDIV_EN undefined:
  - No multiplier/divider logic or CALC datapath is built.
  - Ops 10-17 are treated as illegal: latency 1, result 0, flags 0, err 1.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> result 0x80000000, flags 4'b1010, err 0, out_valid exactly 1 cycle after accept, in_ready back 2 cycles after accept.
- SUB 5-5 -> result 0, flags 4'b0101. SLTU 3,5 -> 1. SLT 0xFFFFFFFF,1 -> 1. SRA 0x80000000 by b=0x24 -> 0xF8000000 (shift 4). Op 20 -> err 1, result 0.
- MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. MULH -> 0xFFFFFFFF. MULHU -> 0x00000001. Each has out_valid exactly 33 cycles after accept and in_ready 0 throughout.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, latency 1; REM same operands -> 0. DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; both latency 1.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Back-pressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> result, flags and out_valid stable; in_valid pulses are not accepted.
  - Assert reset_n=0 mid-CALC (cycle 10 of a DIV) -> out_valid 0 and in_ready 1 without a clock edge; the next op completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with valid/ready handshakes on input and output.
// Base ops (add/sub/logic/shift/compare) finish one cycle after accept.
// The iterative mul/div unit exists only when ALU_MULDIV_EN is defined.
// Without that macro, ops 10-17 complete in one cycle with err set, like illegal ops.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

  // Shared adder: subtraction as a + ~b + 1, reused by the compares
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  always_comb begin
    sub_op = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    b_eff  = sub_op ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    ovf    = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
  end

  // One-cycle result path; also resolves mul/div cases that need no iteration
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_o;
  logic             imm_err;
  logic [3:0]       imm_flags;
`ifdef ALU_MULDIV_EN
  logic             go_calc;
`endif
  always_comb begin
    imm_res = {WIDTH{1'b0}};
    imm_c   = 1'b0;
    imm_o   = 1'b0;
    imm_err = 1'b0;
`ifdef ALU_MULDIV_EN
    go_calc = 1'b0;
`endif
    case (op)
      OP_ADD, OP_SUB: begin imm_res = sum[MSB:0]; imm_c = sum[WIDTH]; imm_o = ovf; end
      OP_SLT:  begin imm_res = {{(WIDTH-1){1'b0}}, sum[MSB] ^ ovf}; imm_c = sum[WIDTH]; imm_o = ovf; end
      OP_SLTU: begin imm_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};   imm_c = sum[WIDTH]; imm_o = ovf; end
      OP_AND:  imm_res = a & b;
      OP_OR:   imm_res = a | b;
      OP_XOR:  imm_res = a ^ b;
      OP_SLL:  imm_res = a << b[SHW-1:0];
      OP_SRL:  imm_res = a >> b[SHW-1:0];
      OP_SRA:  imm_res = $signed(a) >>> b[SHW-1:0];
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: go_calc = 1'b1;
      OP_DIV, OP_REM: begin
        if (b == {WIDTH{1'b0}})
          imm_res = (op == OP_DIV) ? {WIDTH{1'b1}} : a;
        else if ((a == MIN_VAL) && (b == {WIDTH{1'b1}}))
          imm_res = (op == OP_DIV) ? MIN_VAL : {WIDTH{1'b0}};
        else
          go_calc = 1'b1;
      end
      OP_DIVU, OP_REMU: begin
        if (b == {WIDTH{1'b0}})
          imm_res = (op == OP_DIVU) ? {WIDTH{1'b1}} : a;
        else
          go_calc = 1'b1;
      end
`endif
      default: imm_err = 1'b1;
    endcase
    imm_flags = imm_err ? 4'b0000 : {imm_o, imm_c, imm_res[MSB], ~|imm_res};
  end

`ifdef ALU_MULDIV_EN
  // Iterative unit: hi/lo hold accumulator/multiplier for mul, remainder/quotient for div
  logic [4:0]         op_q;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   mag_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   calc_res;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Operand magnitudes; only the signed forms of each op look at the sign bits
  always_comb begin
    a_neg = a[MSB] & ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
    b_neg = b[MSB] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the final value
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_q : {WIDTH{1'b0}})};
    div_shift = {hi_q, lo_q[MSB]};
    div_trial = div_shift - {1'b0, mag_q};
    if (op_q >= OP_DIV) begin
      if (!div_trial[WIDTH]) begin
        hi_d = div_trial[MSB:0];
        lo_d = {lo_q[MSB-1:0], 1'b1};
      end else begin
        hi_d = div_shift[MSB:0];
        lo_d = {lo_q[MSB-1:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[MSB:1]};
    end
    prod = {hi_d, lo_d};
    if (neg_q) prod = -prod;
    calc_res = prod[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:           calc_res = prod[MSB:0];
      OP_DIV, OP_DIVU:  calc_res = neg_q ? -lo_d : lo_d;
      OP_REM, OP_REMU:  calc_res = neg_q ? -hi_d : hi_d;
      default:          ;
    endcase
  end

  // Load operands on accept, then step once per CALC cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= 5'd0;
      cnt_q <= {SHW{1'b0}};
      mag_q <= {WIDTH{1'b0}};
      hi_q  <= {WIDTH{1'b0}};
      lo_q  <= {WIDTH{1'b0}};
      neg_q <= 1'b0;
    end else if ((state_q == IDLE) && in_valid && go_calc) begin
      op_q  <= op;
      cnt_q <= SHW'(WIDTH - 1);
      hi_q  <= {WIDTH{1'b0}};
      if (op >= OP_DIV) begin
        mag_q <= b_mag;
        lo_q  <= a_mag;
        neg_q <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      end else begin
        mag_q <= a_mag;
        lo_q  <= b_mag;
        neg_q <= a_neg ^ b_neg;
      end
    end else if (state_q == CALC) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q != {SHW{1'b0}}) cnt_q <= cnt_q - 1'b1;
    end
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
`ifdef ALU_MULDIV_EN
          if (go_calc) begin
            state_q <= CALC;
          end else
`endif
          begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= imm_res;
            flags_q     <= imm_flags;
            err_q       <= imm_err;
          end
        end
`ifdef ALU_MULDIV_EN
        CALC: if (cnt_q == {SHW{1'b0}}) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          result_q    <= calc_res;
          flags_q     <= {2'b00, calc_res[MSB], ~|calc_res};
          err_q       <= 1'b0;
        end
`endif
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc; the driver queues expected responses from an
// arithmetic reference model, a monitor pops and compares each delivered result.
module tb_alu_mc;
  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op = 5'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  int compared = 0;
  int mismatched = 0;
  int txn = 0;

  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules, using 64-bit integers
  function automatic void model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output exp_t e, output int lat);
    longint sx, sy, t;
    logic [63:0] p;
    logic [W-1:0] r;
    logic c, v, arith, ill;
    sx = $signed(x); sy = $signed(y);
    r = '0; c = 0; v = 0; arith = 0; ill = 0; lat = 1; t = 0; p = '0;
    case (o)
      5'd0: begin p = {32'b0, x} + {32'b0, y}; r = x + y; c = p[32]; t = sx + sy; v = (t > MAXS) || (t < MINS); arith = 1; end
      5'd1: begin r = x - y; c = (x >= y); t = sx - sy; v = (t > MAXS) || (t < MINS); arith = 1; end
      5'd2: r = x & y;
      5'd3: r = x | y;
      5'd4: r = x ^ y;
      5'd5: begin r = (sx < sy) ? 32'd1 : 32'd0; c = (x >= y); t = sx - sy; v = (t > MAXS) || (t < MINS); arith = 1; end
      5'd6: r = x << y[4:0];
      5'd7: r = x >> y[4:0];
      5'd8: r = $signed(x) >>> y[4:0];
      5'd9: begin r = (x < y) ? 32'd1 : 32'd0; c = (x >= y); t = sx - sy; v = (t > MAXS) || (t < MINS); arith = 1; end
`ifdef ALU_MULDIV_EN
      5'd10: begin p = sx * sy; r = p[31:0]; lat = 33; end
      5'd11: begin p = sx * sy; r = p[63:32]; lat = 33; end
      5'd12: begin t = sx * longint'({32'b0, y}); p = t; r = p[63:32]; lat = 33; end
      5'd13: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; lat = 33; end
      5'd14: begin
        if (y == 0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
        else begin t = sx / sy; r = t[31:0]; lat = 33; end
      end
      5'd15: begin if (y == 0) r = 32'hFFFFFFFF; else begin r = x / y; lat = 33; end end
      5'd16: begin
        if (y == 0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
        else begin t = sx % sy; r = t[31:0]; lat = 33; end
      end
      5'd17: begin if (y == 0) r = x; else begin r = x % y; lat = 33; end end
`endif
      default: ill = 1;
    endcase
    e.op    = o;
    e.err   = ill;
    e.res   = ill ? '0 : r;
    e.flags = ill ? 4'b0000 : {arith & v, arith & c, r[31], (r == 0)};
  endfunction

  // Monitor: one pop and compare per delivered result
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got result 0x%h flags %b err %b, expected no output", result, flags, err);
      end else begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d op %0d -> result 0x%h flags %b err %b", txn, e.op, result, flags, err);
        chk($sformatf("result_op%0d", e.op), {27'b0, result, flags, err}, {27'b0, e.res, e.flags, e.err});
      end
    end
  end

  // Issue one op, check latency/busy, optionally hold off the consumer, then check release
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    exp_t e;
    int lat, n;
    logic busy_ok, stable_ok;
    model(o, x, y, e, lat);
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_wait", in_ready, 1'b1);
    sb_q.push_back(e);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    n = 1; busy_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    if (in_ready) busy_ok = 1'b0;
    chk($sformatf("latency_op%0d", o), n, lat);
    chk($sformatf("busy_op%0d", o), busy_ok, 1'b1);
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; op = 5'($urandom); a = $urandom; b = $urandom;
        @(posedge clk); #1;
        if (!(out_valid && !in_ready && result === e.res && flags === e.flags && err === e.err))
          stable_ok = 1'b0;
      end
      in_valid = 1'b0;
      chk($sformatf("hold_stable_op%0d", o), stable_ok, 1'b1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk($sformatf("release_op%0d", o), {in_ready, out_valid}, 2'b10);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0]   d_op [19] = '{5'd0, 5'd1, 5'd9, 5'd5, 5'd8, 5'd20, 5'd10, 5'd11, 5'd13, 5'd14,
                              5'd16, 5'd15, 5'd17, 5'd14, 5'd16, 5'd15, 5'd17, 5'd6, 5'd12};
  logic [W-1:0] d_a  [19] = '{32'h7FFFFFFF, 32'd5, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'h12345678,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                              32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h1, 32'hFFFFFFFE};
  logic [W-1:0] d_b  [19] = '{32'd1, 32'd5, 32'd5, 32'd1, 32'h24, 32'h1, 32'd2, 32'd2, 32'd2,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2, 32'd7, 32'd7,
                              32'd31, 32'd3};
  int           d_hold [19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 2};

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {27'b0, in_ready, out_valid, result, flags, err}, {27'b0, 1'b1, 1'b0, 32'h0, 4'b0, 1'b0});
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) run_op(d_op[i], d_a[i], d_b[i], d_hold[i]);

    // Reset while busy: DIV mid-iteration (or held in DONE when mul/div is not built)
    out_ready = 1'b0;
    in_valid = 1'b1; op = 5'd14; a = 32'h00123456; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset", {27'b0, in_ready, out_valid, result, flags, err}, {27'b0, 1'b1, 1'b0, 32'h0, 4'b0, 1'b0});
    sb_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    run_op(5'd14, 32'hFFFFFF9C, 32'd7, 0);

    for (int i = 0; i < 150; i++) begin
      logic [4:0] o;
      o = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      run_op(o, rnd_operand(), rnd_operand(), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog timeout");
  end
endmodule
